// File: rtl/indirect_fifo_ctrl.sv
// Indirect FIFO access controller.
// Lets a CPU reach a FIFO through a single CSR: a CSR write pushes one word
// and a CSR read pops one word. While no CSR write is pending, the I3C-side
// write stream passes straight through to the FIFO write port.
module indirect_fifo_ctrl #(
    parameter int Width    = 32,
    parameter int StallMax = 16,
    parameter int DepthW   = 7
) (
    input  logic              aclk,
    input  logic              areset_n,
    // CSR side
    input  logic              csr_req_i,
    input  logic              csr_req_is_wr_i,
    input  logic [Width-1:0]  csr_wr_data_i,
    output logic              csr_wr_ack_o,
    output logic              csr_rd_ack_o,
    output logic [Width-1:0]  csr_rd_data_o,
    // I3C-side write stream
    input  logic              bus_wvalid_i,
    input  logic [Width-1:0]  bus_wdata_i,
    output logic              bus_wready_o,
    // FIFO ports
    output logic              fifo_wvalid_o,
    output logic [Width-1:0]  fifo_wdata_o,
    input  logic              fifo_wready_i,
    input  logic              fifo_rvalid_i,
    input  logic [Width-1:0]  fifo_rdata_i,
    output logic              fifo_rready_o,
    input  logic [DepthW-1:0] fifo_depth_i,
    // control / status
    input  logic              clr_i,
    output logic              fifo_clr_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              busy_o
);

    localparam int CntW = $clog2(StallMax + 1);
    // Counter value on the last stalled cycle a write may spend waiting.
    localparam logic [CntW-1:0] StallLast = CntW'(StallMax - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CSR_WR = 2'd1,
        CSR_RD = 2'd2,
        ACK    = 2'd3
    } state_e;

    state_e            state_r, state_s;
    logic              is_wr_r, is_wr_s;
    logic [Width-1:0]  data_r, data_s;
    logic [CntW-1:0]   stall_cnt_r, stall_cnt_s;
    logic              ovf_r, ovf_s;
    logic              unf_r, unf_s;
    logic              wr_ack_r, wr_ack_s;
    logic              rd_ack_r, rd_ack_s;
    logic [Width-1:0]  rd_data_r, rd_data_s;

    // Occupancy is informational only; the controller relies on ready/valid.
    logic              depth_unused_s;
    assign depth_unused_s = ^fifo_depth_i;

    // Next-state, capture, stall counting, sticky flags and ack generation.
    always_comb begin
        state_s     = state_r;
        is_wr_s     = is_wr_r;
        data_s      = data_r;
        stall_cnt_s = stall_cnt_r;
        ovf_s       = ovf_r;
        unf_s       = unf_r;
        wr_ack_s    = 1'b0;
        rd_ack_s    = 1'b0;
        rd_data_s   = {Width{1'b0}};
        case (state_r)
            IDLE: begin
                if (csr_req_i) begin
                    data_s      = csr_wr_data_i;
                    is_wr_s     = csr_req_is_wr_i;
                    stall_cnt_s = {CntW{1'b0}};
                    state_s     = csr_req_is_wr_i ? CSR_WR : CSR_RD;
                end else begin
                    state_s = IDLE;
                end
            end
            CSR_WR: begin
                if (clr_i) begin
                    // Abort: the CPU still gets its ack, nothing is written.
                    state_s  = ACK;
                    wr_ack_s = 1'b1;
                end else if (fifo_wready_i) begin
                    state_s  = ACK;
                    wr_ack_s = 1'b1;
                end else if (stall_cnt_r == StallLast) begin
                    // Give up on a persistently full FIFO and drop the word.
                    ovf_s    = 1'b1;
                    state_s  = ACK;
                    wr_ack_s = 1'b1;
                end else begin
                    stall_cnt_s = stall_cnt_r + {{(CntW-1){1'b0}}, 1'b1};
                end
            end
            CSR_RD: begin
                state_s  = ACK;
                rd_ack_s = 1'b1;
                if (clr_i) begin
                    rd_data_s = {Width{1'b0}};
                end else if (fifo_rvalid_i) begin
                    rd_data_s = fifo_rdata_i;
                end else begin
                    rd_data_s = {Width{1'b0}};
                    unf_s     = 1'b1;
                end
            end
            ACK: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // Clearing takes priority over any flag set in the same cycle.
        if (clr_i) begin
            ovf_s = 1'b0;
            unf_s = 1'b0;
        end else begin
            ovf_s = ovf_s;
            unf_s = unf_s;
        end
    end

    // State and datapath registers.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_r     <= IDLE;
            is_wr_r     <= 1'b0;
            data_r      <= {Width{1'b0}};
            stall_cnt_r <= {CntW{1'b0}};
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            wr_ack_r    <= 1'b0;
            rd_ack_r    <= 1'b0;
            rd_data_r   <= {Width{1'b0}};
        end else begin
            state_r     <= state_s;
            is_wr_r     <= is_wr_s;
            data_r      <= data_s;
            stall_cnt_r <= stall_cnt_s;
            ovf_r       <= ovf_s;
            unf_r       <= unf_s;
            wr_ack_r    <= wr_ack_s;
            rd_ack_r    <= rd_ack_s;
            rd_data_r   <= rd_data_s;
        end
    end

    // FIFO port ownership: CSR owns the write port only while in CSR_WR.
    always_comb begin
        fifo_wvalid_o = bus_wvalid_i;
        fifo_wdata_o  = bus_wdata_i;
        bus_wready_o  = fifo_wready_i;
        fifo_rready_o = 1'b0;
        case (state_r)
            CSR_WR: begin
                fifo_wvalid_o = ~clr_i;
                fifo_wdata_o  = data_r;
                bus_wready_o  = 1'b0;
            end
            CSR_RD: begin
                fifo_rready_o = fifo_rvalid_i & ~clr_i;
            end
            default: begin
                fifo_rready_o = 1'b0;
            end
        endcase
    end

    assign csr_wr_ack_o  = wr_ack_r;
    assign csr_rd_ack_o  = rd_ack_r;
    assign csr_rd_data_o = rd_data_r;
    assign fifo_clr_o    = clr_i;
    assign overflow_o    = ovf_r;
    assign underflow_o   = unf_r;
    assign busy_o        = (state_r != IDLE);

endmodule

// File: doc/indirect_fifo_ctrl.md
INDIRECT_FIFO_CTRL -- requirements
Module: indirect_fifo_ctrl

Interface
REQ-001 SHALL have parameter Width, default 32: data width of the CSR, bus and FIFO ports.
REQ-002 SHALL have parameter StallMax, default 16: maximum number of cycles a CSR write waits on a full FIFO.
REQ-003 SHALL have parameter DepthW, default 7: width of fifo_depth_i.
REQ-004 aclk  in  1  clock; all logic rising-edge.
REQ-005 areset_n  in  1  reset, asynchronous, active-low.
REQ-006 csr_req_i  in  1  one-cycle CSR access pulse from the register block external port.
REQ-007 csr_req_is_wr_i  in  1  1 = write, 0 = read; qualified by csr_req_i.
REQ-008 csr_wr_data_i  in  Width  CSR write data; qualified by csr_req_i.
REQ-009 csr_wr_ack_o  out  1  one-cycle write acknowledge.
REQ-010 csr_rd_ack_o  out  1  one-cycle read acknowledge.
REQ-011 csr_rd_data_o  out  Width  read data; valid only while csr_rd_ack_o=1, else 0.
REQ-012 bus_wvalid_i / bus_wdata_i  in  1 / Width  I3C-side write stream.
REQ-013 bus_wready_o  out  1  I3C-side write ready.
REQ-014 fifo_wvalid_o / fifo_wdata_o  out  1 / Width  FIFO write port.
REQ-015 fifo_wready_i  in  1  FIFO write ready (low when full).
REQ-016 fifo_rvalid_i / fifo_rdata_i  in  1 / Width  FIFO read port (rvalid low when empty).
REQ-017 fifo_rready_o  out  1  FIFO read pop.
REQ-018 fifo_depth_i  in  DepthW  current FIFO occupancy, status only.
REQ-019 clr_i  in  1  synchronous clear request.
REQ-020 fifo_clr_o  out  1  equals clr_i, combinational.
REQ-021 overflow_o  out  1  sticky: a CSR write was dropped.
REQ-022 underflow_o  out  1  sticky: a CSR read was made from an empty FIFO.
REQ-023 busy_o  out  1  1 whenever the state is not IDLE.

Function
REQ-024 FSM states: IDLE, CSR_WR, CSR_RD, ACK.
REQ-025 IDLE: csr_req_i=1 captures csr_wr_data_i and the access direction; next state CSR_WR if write, else CSR_RD.
REQ-026 csr_req_i outside IDLE SHALL be ignored, with no state, flag or output change.
REQ-027 CSR_WR: fifo_wvalid_o=1 and fifo_wdata_o=captured data; fifo_wready_i=1 -> ACK.
REQ-028 CSR_WR stall counter: starts at 0 on entry and increments each cycle fifo_wready_i=0.
REQ-029 When the stall counter reaches StallMax with no handshake: no FIFO write; set overflow_o; go to ACK.
REQ-030 CSR_RD with fifo_rvalid_i=1: fifo_rready_o=1 for exactly one cycle; latch fifo_rdata_i; go to ACK.
REQ-031 CSR_RD with fifo_rvalid_i=0: no pop; latched data=0; set underflow_o; go to ACK.
REQ-032 ACK: pulse csr_wr_ack_o or csr_rd_ack_o (matching the captured direction) for exactly one cycle; return to IDLE.
REQ-033 Latency: csr_req_i in cycle N with a non-full FIFO (write) or non-empty FIFO (read) -> ack in cycle N+2.
REQ-034 Bus pass-through in IDLE, CSR_RD and ACK: fifo_wvalid_o=bus_wvalid_i, fifo_wdata_o=bus_wdata_i, bus_wready_o=fifo_wready_i.
REQ-035 In CSR_WR: bus_wready_o=0; the FIFO write port is owned by the CSR.
REQ-036 Bus handshake in the same IDLE cycle as a CSR write request: the bus beat completes that cycle, then the CSR write proceeds.
REQ-037 After a CSR write, the bus gets at least one grant opportunity in ACK before any next CSR write.
REQ-038 fifo_rready_o SHALL be 0 in every state except CSR_RD.
REQ-039 clr_i in CSR_WR or CSR_RD: abort with no FIFO access; go to ACK with data 0 so the CPU never hangs.
REQ-040 clr_i in any state: clears overflow_o and underflow_o.
REQ-041 Same-cycle set and clr_i on a sticky flag: clear wins.
REQ-042 clr_i in IDLE together with csr_req_i: the request is accepted.

Reset
REQ-043 areset_n low: state=IDLE, stall counter=0, captured data=0, all acks=0.
REQ-044 areset_n low: overflow_o=0, underflow_o=0, busy_o=0, fifo_rready_o=0.
REQ-045 Reset asserted mid-access: the pending access is discarded and no ack is issued.

Verification
REQ-046 CSR write 0xA5A5_0001 to an empty FIFO -> fifo write of 0xA5A5_0001 in cycle N+1; csr_wr_ack_o in N+2; busy_o=0 in N+3.
REQ-047 Push 0x1234 via bus, then CSR read -> one fifo_rready_o pulse; csr_rd_ack_o with csr_rd_data_o=0x1234 at N+2.
REQ-048 CSR read with an empty FIFO -> ack at N+2 with data 0; underflow_o=1 until clr_i.
REQ-049 fifo_wready_i held 0 and CSR write -> no write; ack after StallMax (16) stall cycles; overflow_o=1; bus_wready_o=0 throughout CSR_WR.
REQ-050 bus_wvalid_i held 1 with back-to-back CSR writes -> bus beats accepted in every IDLE/ACK cycle; no data lost or reordered against the scoreboard.
REQ-051 areset_n pulsed during CSR_WR -> no ack; all outputs at reset values.
